// File: rtl/lcd_pwr_seq_if.sv
// Signal bundle between the LCD power sequencer and the panel/driver side.
// The master drives the strap bus and on/off requests; the slave is the sequencer.
interface lcd_pwr_seq_if;
  logic [15:0] lcd_rgb_i;
  logic        on_req;
  logic        off_req;
  logic        lcd_rst;
  logic        rgb_oe;
  logic        disp_en;
  logic        lcd_bl;
  logic [15:0] lcd_id;
  logic        id_valid;
  logic        busy;

  modport master (output lcd_rgb_i, on_req, off_req,
                  input  lcd_rst, rgb_oe, disp_en, lcd_bl, lcd_id, id_valid, busy);
  modport slave  (input  lcd_rgb_i, on_req, off_req,
                  output lcd_rst, rgb_oe, disp_en, lcd_bl, lcd_id, id_valid, busy);
endinterface

// File: rtl/lcd_pwr_seq.sv
// LCD power-up / ID-strap read / backlight sequencer with registered outputs.
// Define LCD_ID_FORCE_EN to skip the strap read and report FORCE_ID instead.
module lcd_pwr_seq #(
  parameter int unsigned RST_CYC     = 500000,
  parameter int unsigned ID_WAIT_CYC = 1000,
  parameter int unsigned SAMPLE_CNT  = 4,
  parameter int unsigned BL_DLY_CYC  = 2500000,
  parameter logic [15:0] FORCE_ID    = 16'h4342
) (
  input  logic         clk,
  input  logic         rst,
  lcd_pwr_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_RST, S_WAIT, S_SAMPLE, S_LATCH, S_DISP, S_ON, S_BLOFF, S_OFF
  } state_t;

  typedef struct packed {
    logic lcd_rst;
    logic rgb_oe;
    logic disp_en;
    logic lcd_bl;
    logic busy;
  } outs_t;

  localparam int          MW         = $clog2(SAMPLE_CNT + 1);
  localparam logic [23:0] L_RST_END  = 24'(RST_CYC - 1);
  localparam logic [23:0] L_WAIT_END = 24'(ID_WAIT_CYC - 1);
  localparam logic [23:0] L_BL_END   = 24'(BL_DLY_CYC - 1);
  localparam outs_t       L_OUT_RST  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef LCD_ID_FORCE_EN
  localparam state_t      L_AFTER_WAIT = S_LATCH;
`else
  localparam state_t      L_AFTER_WAIT = S_SAMPLE;
  localparam logic [MW-1:0] L_MATCH    = MW'(SAMPLE_CNT);
`endif

  state_t      r_state, w_nxt;
  logic [23:0] r_cnt;
  outs_t       r_out, w_out;
  logic [15:0] r_id, w_id;
  logic        r_id_valid;

`ifdef LCD_ID_FORCE_EN
  // Strap bus is deliberately ignored in this build.
  logic w_unused;
  assign w_unused = ^bus.lcd_rgb_i;
`else
  logic          w_unused;
  logic [2:0]    w_code;
  logic [2:0]    r_prev;
  logic [MW-1:0] r_match, w_match;

  assign w_unused = ^FORCE_ID;
  // Straps {B7,G7,R7}; r_match==0 marks the first sample cycle (no prior sample).
  assign w_code   = {bus.lcd_rgb_i[15], bus.lcd_rgb_i[10], bus.lcd_rgb_i[4]};

  always_comb begin
    w_match = MW'(1);
    if (r_match != '0 && w_code == r_prev) w_match = r_match + MW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= 3'b000;
      r_match <= '0;
    end else if (r_state == S_SAMPLE) begin
      r_prev  <= w_code;
      r_match <= w_match;
    end else begin
      r_match <= '0;
    end
  end
`endif

  // State register and the shared phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt != r_state) ? 24'd0 : r_cnt + 24'd1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_RST:    if (r_cnt == L_RST_END)  w_nxt = S_WAIT;
      S_WAIT:   if (r_cnt == L_WAIT_END) w_nxt = L_AFTER_WAIT;
`ifdef LCD_ID_FORCE_EN
      S_SAMPLE: w_nxt = S_LATCH;
`else
      S_SAMPLE: if (w_match == L_MATCH)  w_nxt = S_LATCH;
`endif
      S_LATCH:  w_nxt = S_DISP;
      S_DISP:   if (r_cnt == L_BL_END)   w_nxt = S_ON;
      S_ON:     if (bus.off_req)         w_nxt = S_BLOFF;
      S_BLOFF:  if (r_cnt == L_BL_END)   w_nxt = S_OFF;
      // Simultaneous on/off in S_OFF resolves to off.
      S_OFF:    if (bus.on_req && !bus.off_req) w_nxt = S_DISP;
      default:  w_nxt = S_RST;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    w_out         = '0;
    w_out.lcd_rst = 1'b1;
    w_out.busy    = 1'b1;
    case (w_nxt)
      S_RST:   w_out.lcd_rst = 1'b0;
      S_DISP,
      S_BLOFF: begin
        w_out.rgb_oe  = 1'b1;
        w_out.disp_en = 1'b1;
      end
      S_ON: begin
        w_out.rgb_oe  = 1'b1;
        w_out.disp_en = 1'b1;
        w_out.lcd_bl  = 1'b1;
        w_out.busy    = 1'b0;
      end
      S_OFF:   w_out.busy = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    w_id = r_id;
    if (w_nxt == S_LATCH) begin
`ifdef LCD_ID_FORCE_EN
      w_id = FORCE_ID;
`else
      case (w_code)
        3'b000:  w_id = 16'h4342;
        3'b001:  w_id = 16'h7084;
        3'b010:  w_id = 16'h7016;
        3'b100:  w_id = 16'h4384;
        3'b101:  w_id = 16'h1018;
        default: w_id = 16'h0000;
      endcase
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= L_OUT_RST;
      r_id       <= 16'h0000;
      r_id_valid <= 1'b0;
    end else begin
      r_out <= w_out;
      r_id  <= w_id;
      if (r_state == S_LATCH) r_id_valid <= 1'b1;
    end
  end

  assign bus.lcd_rst  = r_out.lcd_rst;
  assign bus.rgb_oe   = r_out.rgb_oe;
  assign bus.disp_en  = r_out.disp_en;
  assign bus.lcd_bl   = r_out.lcd_bl;
  assign bus.busy     = r_out.busy;
  assign bus.lcd_id   = r_id;
  assign bus.id_valid = r_id_valid;

endmodule

// File: tb/tb_lcd_pwr_seq.sv
// Directed table-driven bench for lcd_pwr_seq (RST=10, WAIT=4, SAMPLE=3, BL=8).
// Honours LCD_ID_FORCE_EN for the ID-read portions.
module tb_lcd_pwr_seq;

  typedef struct {
    logic        rst;
    logic [15:0] rgb;
    logic        on;
    logic        off;
    int          n;
    logic [21:0] exp;   // {lcd_rst, rgb_oe, disp_en, lcd_bl, busy, id_valid, lcd_id}
  } vec_t;

  localparam logic [15:0] S000 = 16'h7BEF;  // all non-strap bits set, straps 000
  localparam logic [15:0] S001 = 16'h0010;
  localparam logic [15:0] S010 = 16'h0400;
  localparam logic [15:0] S101 = 16'h8010;
  localparam logic [15:0] S111 = 16'h8410;
  localparam logic [15:0] I    = 16'h4342;
`ifdef LCD_ID_FORCE_EN
  localparam int EXP_LAT = 15;
`else
  localparam int EXP_LAT = 18;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  lcd_pwr_seq_if bus();

  lcd_pwr_seq #(
    .RST_CYC(10), .ID_WAIT_CYC(4), .SAMPLE_CNT(3), .BL_DLY_CYC(8), .FORCE_ID(16'h4342)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] obs();
    return {bus.lcd_rst, bus.rgb_oe, bus.disp_en, bus.lcd_bl, bus.busy, bus.id_valid, bus.lcd_id};
  endfunction

  function automatic void add(input logic r, input logic [15:0] rgb, input logic on,
                              input logic off, input int n, input logic lr, input logic oe,
                              input logic de, input logic bl, input logic bz, input logic v,
                              input logic [15:0] id);
    vec_t t;
    t.rst = r; t.rgb = rgb; t.on = on; t.off = off; t.n = n;
    t.exp = {lr, oe, de, bl, bz, v, id};
    vq.push_back(t);
  endfunction

  // Advance n cycles; rgb_oe must never be up without lcd_rst high and disp_en high.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.rgb_oe && (!bus.lcd_rst || !bus.disp_en)) begin
        n_err++;
        $display("FAIL oe_guard t=%0t: rgb_oe=%b lcd_rst=%b disp_en=%b, required rgb_oe=0",
                 $time, bus.rgb_oe, bus.lcd_rst, bus.disp_en);
      end
    end
  endtask

  initial begin
    int cyc;
    bus.lcd_rgb_i = S000;
    bus.on_req    = 1'b0;
    bus.off_req   = 1'b0;

    // Power-up to S_ON
`ifdef LCD_ID_FORCE_EN
    add(1, S111, 0, 0, 2, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S111, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S111, 0, 0, 8, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S111, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S111, 0, 0, 3, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S111, 0, 0, 1, 1, 0, 0, 0, 1, 0, I);
    add(0, S111, 0, 0, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S111, 0, 0, 7, 1, 1, 1, 0, 1, 1, I);
    add(0, S111, 0, 0, 1, 1, 1, 1, 1, 0, 1, I);
`else
    add(1, S000, 0, 0, 2, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 8, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 4, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 2, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 1, 1, 0, 0, 0, 1, 0, I);
    add(0, S000, 0, 0, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 7, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 1, 1, 1, 1, 1, 0, 1, I);
`endif
    // On/off handshakes
    add(0, S000, 1, 0, 2, 1, 1, 1, 1, 0, 1, I);
    add(0, S000, 0, 1, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 7, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 1, 1, 0, 0, 0, 0, 1, I);
    add(0, S000, 0, 0, 2, 1, 0, 0, 0, 0, 1, I);
    add(0, S000, 1, 0, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 7, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 1, 1, 1, 1, 1, 0, 1, I);
    add(0, S000, 1, 1, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 8, 1, 0, 0, 0, 0, 1, I);
    add(0, S000, 1, 1, 1, 1, 0, 0, 0, 0, 1, I);
    add(0, S000, 0, 0, 2, 1, 0, 0, 0, 0, 1, I);
    add(0, S000, 1, 0, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 1, 1, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 6, 1, 1, 1, 0, 1, 1, I);
    add(0, S000, 0, 0, 1, 1, 1, 1, 1, 0, 1, I);
    // Reset while in S_ON
    add(1, S000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 9, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
`ifdef LCD_ID_FORCE_EN
    add(0, S000, 0, 0, 4, 1, 0, 0, 0, 1, 0, I);
    add(0, S000, 0, 0, 1, 1, 1, 1, 0, 1, 1, I);
`else
    // Reset mid-S_SAMPLE, then toggling straps before they settle on 101
    add(0, S000, 0, 0, 4, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(1, S000, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S000, 0, 0, 10, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S001, 0, 0, 4, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S010, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S001, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S010, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S001, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S010, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S101, 0, 0, 2, 1, 0, 0, 0, 1, 0, 16'h0000);
    add(0, S101, 0, 0, 1, 1, 0, 0, 0, 1, 0, 16'h1018);
    add(0, S101, 0, 0, 1, 1, 1, 1, 0, 1, 1, 16'h1018);
`endif

    foreach (vq[i]) begin
      rst           = vq[i].rst;
      bus.lcd_rgb_i = vq[i].rgb;
      bus.on_req    = vq[i].on;
      bus.off_req   = vq[i].off;
      step(vq[i].n);
      n_vec++;
      if (obs() !== vq[i].exp) begin
        n_err++;
        $display("FAIL vec%0d: got {rst,oe,de,bl,busy,vld,id}=%h, required %h",
                 i, obs(), vq[i].exp);
      end
    end

    // Full replay from reset: count cycles until id_valid, bounded.
    bus.on_req    = 1'b0;
    bus.off_req   = 1'b0;
    bus.lcd_rgb_i = S000;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    cyc = 0;
    while (!bus.id_valid && cyc < 100) begin
      step(1);
      cyc++;
    end
    n_vec++;
    if (cyc != EXP_LAT) begin
      n_err++;
      $display("FAIL id_latency: got %0d cycles, required %0d", cyc, EXP_LAT);
    end
    n_vec++;
    if (bus.lcd_id !== I) begin
      n_err++;
      $display("FAIL replay_id: got %h, required %h", bus.lcd_id, I);
    end
    step(8);
    n_vec++;
    if (!(bus.lcd_bl === 1'b1 && bus.busy === 1'b0)) begin
      n_err++;
      $display("FAIL replay_on: got lcd_bl=%b busy=%b, required 1/0", bus.lcd_bl, bus.busy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_pwr_seq.md
LCD_PWR_SEQ -- requirements
Module: lcd_pwr_seq

Interface
REQ-001 Parameter RST_CYC, default 500000, panel reset low time in clk cycles (10 ms at 50 MHz).
REQ-002 Parameter ID_WAIT_CYC, default 1000, settle cycles after panel reset release before the first ID sample.
REQ-003 Parameter SAMPLE_CNT, default 4, number of consecutive identical ID samples required.
REQ-004 Parameter BL_DLY_CYC, default 2500000, delay between display enable and backlight change.
REQ-005 Parameter FORCE_ID, default 16'h4342, ID used when LCD_ID_FORCE_EN is defined.
REQ-006 clk  input  1  system clock; the block has one clock and all logic is on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 lcd_rgb_i  input  16  sampled RGB565 bus; ID straps are R7=bit4, G7=bit10, B7=bit15.
REQ-009 on_req  input  1  single-cycle request to turn the display on.
REQ-010 off_req  input  1  single-cycle request to turn the display off.
REQ-011 lcd_rst  output  1  active-low panel reset.
REQ-012 rgb_oe  output  1  1 = the driver may drive lcd_rgb; 0 = the bus is released.
REQ-013 disp_en  output  1  enables the timing driver.
REQ-014 lcd_bl  output  1  backlight enable.
REQ-015 lcd_id  output  16  decoded panel ID.
REQ-016 id_valid  output  1  lcd_id is stable and valid; stays high until reset.
REQ-017 busy  output  1  high in every state except S_ON and S_OFF.

Function
REQ-018 FSM states: S_RST, S_WAIT, S_SAMPLE, S_LATCH, S_DISP, S_ON, S_BLOFF, S_OFF; one shared 24-bit counter, cleared on every state change.
REQ-019 S_RST: lcd_rst=0, rgb_oe=0; exit to S_WAIT when counter==RST_CYC-1, so lcd_rst is low exactly RST_CYC cycles after reset deasserts.
REQ-020 S_WAIT: lcd_rst=1, rgb_oe=0; exit to S_SAMPLE when counter==ID_WAIT_CYC-1.
REQ-021 S_SAMPLE: sample {B7,G7,R7} every cycle.
- If the sample equals the previous sample, increment the match count; otherwise reload the match count to 1.
- Exit to S_LATCH in the cycle the match count reaches SAMPLE_CNT.
REQ-022 S_LATCH lasts 1 cycle and registers lcd_id from the matched code:
- 000->16'h4342, 001->16'h7084, 010->16'h7016, 100->16'h4384, 101->16'h1018
- any other code -> 16'h0000
- id_valid rises in the following cycle.
REQ-023 S_DISP: disp_en=1, rgb_oe=1, lcd_bl=0; exit to S_ON when counter==BL_DLY_CYC-1.
REQ-024 S_ON: lcd_bl=1; off_req moves to S_BLOFF.
REQ-025 S_BLOFF: lcd_bl=0 from the first cycle, disp_en=1; exit to S_OFF when counter==BL_DLY_CYC-1.
REQ-026 S_OFF: disp_en=0, rgb_oe=0, lcd_bl=0, lcd_rst=1; on_req moves to S_DISP.
REQ-027 on_req and off_req are ignored in all states except S_ON (off_req) and S_OFF (on_req); requests are not queued.
REQ-028 If on_req and off_req are both asserted in S_ON, go to S_BLOFF; if both are asserted in S_OFF, stay in S_OFF (off wins).
REQ-029 rgb_oe is never 1 while lcd_rst=0 or while in S_WAIT or S_SAMPLE (no bus contention during ID read).
REQ-030 All outputs are registered; outputs change 1 cycle after the state transition that causes them.

Reset
REQ-031 While rst=1, and in the first cycle after it deasserts:
- state=S_RST
- lcd_rst=0, rgb_oe=0, disp_en=0, lcd_bl=0
- lcd_id=16'h0000, id_valid=0, busy=1
- counters cleared
REQ-032 Reset asserted in any state, including mid-S_SAMPLE or S_ON, aborts the sequence immediately and restarts it from S_RST with a new ID read.

Configuration
REQ-033 With macro LCD_ID_FORCE_EN defined: S_WAIT exits to S_LATCH (S_SAMPLE is skipped), lcd_id=FORCE_ID, and lcd_rgb_i is ignored.
REQ-034 Without LCD_ID_FORCE_EN: the ID is read from the straps as specified in REQ-021 and REQ-022.

Verification (bench parameters RST_CYC=10, ID_WAIT_CYC=4, SAMPLE_CNT=3, BL_DLY_CYC=8)
REQ-035 Release rst, straps=000 -> lcd_rst low 10 cycles; after 4 wait cycles and 3 matching samples, lcd_id=16'h4342 and id_valid=1; disp_en=1; lcd_bl=1 exactly 8 cycles later; busy=0.
REQ-036 Straps toggle 001/010 for 5 cycles, then hold 101 -> no latch during toggling; lcd_id=16'h1018 three cycles after the straps settle.
REQ-037 In S_ON, pulse off_req -> lcd_bl=0 next cycle; disp_en and rgb_oe drop 8 cycles later; then pulse on_req -> disp_en=1 and lcd_bl=1 after 8 more cycles.
REQ-038 Pulse on_req and off_req together in S_ON and again in S_OFF -> goes to S_BLOFF, then stays in S_OFF; a request pulsed during S_DISP has no effect.
REQ-039 Assert rst for 1 cycle mid-S_SAMPLE and again in S_ON -> all outputs return to reset values and the full sequence replays.
REQ-040 Build with LCD_ID_FORCE_EN and straps=111 -> lcd_id=FORCE_ID 16'h4342 after 10+4+1 cycles; rgb_oe never rises before disp_en.
